uart_cmd_decoder: RTL and testbench

Consumes the byte stream produced by the UART receive path (parallel data, valid pulse, parity/frame error flags) and assembles multi-byte command frames. Decoded frames become a single command beat toward the register file / ALU controller, under a valid/ready handshake. Erroneous or unknown bytes are reported and discarded.

---
 rtl/uart_cmd_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles UART receive bytes into command frames and
// issues each decoded frame as one command beat under a valid/ready handshake.
// Bad bytes (line errors, unknown opcodes, overruns) are dropped and reported
// on err_pulse/err_code.
// Optional build macro: CMD_TIMEOUT_EN enables the inter-byte timeout that
// abandons a partial frame after TIMEOUT_CYC idle cycles in a payload state.
module uart_cmd_decoder #(
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_par_err,
  input  logic              rx_frame_err,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [1:0]        cmd_type,
  output logic [DATA_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  output logic [DATA_W-1:0] cmd_opa,
  output logic [DATA_W-1:0] cmd_opb,
  output logic [3:0]        cmd_fun,
  output logic              err_pulse,
  output logic [2:0]        err_code
);

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    ALU_A,
    ALU_B,
    ALU_FUN,
    NOOP_FUN,
    ISSUE
  } state_e;

  localparam logic [1:0] TypeRfWr   = 2'd0;
  localparam logic [1:0] TypeRfRd   = 2'd1;
  localparam logic [1:0] TypeAluOps = 2'd2;
  localparam logic [1:0] TypeAluNop = 2'd3;

  localparam logic [2:0] ErrLine    = 3'd1;
  localparam logic [2:0] ErrOpcode  = 3'd2;
  localparam logic [2:0] ErrOverrun = 3'd3;

  state_e              state_q, state_d;
  logic [1:0]          type_q, type_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   opa_q, opa_d;
  logic [DATA_W-1:0]   opb_q, opb_d;
  logic [3:0]          fun_q, fun_d;
  logic                errPulse_q, errPulse_d;
  logic [2:0]          errCode_q, errCode_d;
  logic                lineErr;

  assign lineErr = rx_par_err | rx_frame_err;

`ifdef CMD_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] ErrTimeout = 3'd4;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            inPayload;

  assign inPayload = (state_q != IDLE) && (state_q != ISSUE);
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
`endif

  // Register the FSM state, the frame payload and the error reporting outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      type_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      fun_q      <= '0;
      errPulse_q <= 1'b0;
      errCode_q  <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      fun_q      <= fun_d;
      errPulse_q <= errPulse_d;
      errCode_q  <= errCode_d;
    end
  end

`ifdef CMD_TIMEOUT_EN
  // Inter-byte idle counter, only advancing while a frame is partially received
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Decode the byte stream: opcode dispatch, payload capture, issue handshake
  // and selection of the single error reported this cycle
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    fun_d      = fun_q;
    errPulse_d = 1'b0;
    errCode_d  = '0;
`ifdef CMD_TIMEOUT_EN
    cnt_d      = '0;
`endif

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (lineErr) begin
            errPulse_d = 1'b1;
            errCode_d  = ErrLine;
          end else if (rx_data == DATA_W'(8'hAA)) begin
            type_d  = TypeRfWr;
            state_d = WR_ADDR;
          end else if (rx_data == DATA_W'(8'hBB)) begin
            type_d  = TypeRfRd;
            state_d = RD_ADDR;
          end else if (rx_data == DATA_W'(8'hCC)) begin
            type_d  = TypeAluOps;
            state_d = ALU_A;
          end else if (rx_data == DATA_W'(8'hDD)) begin
            type_d  = TypeAluNop;
            state_d = NOOP_FUN;
          end else begin
            errPulse_d = 1'b1;
            errCode_d  = ErrOpcode;
          end
        end
      end

      ISSUE: begin
        if (cmd_ready) begin
          state_d = IDLE;
        end
        if (rx_valid) begin
          errPulse_d = 1'b1;
          errCode_d  = ErrOverrun;
        end
      end

      default: begin
        if (rx_valid) begin
          if (lineErr) begin
            state_d    = IDLE;
            errPulse_d = 1'b1;
            errCode_d  = ErrLine;
          end else begin
            case (state_q)
              WR_ADDR: begin
                addr_d  = rx_data;
                state_d = WR_DATA;
              end
              WR_DATA: begin
                wdata_d = rx_data;
                state_d = ISSUE;
              end
              RD_ADDR: begin
                addr_d  = rx_data;
                state_d = ISSUE;
              end
              ALU_A: begin
                opa_d   = rx_data;
                state_d = ALU_B;
              end
              ALU_B: begin
                opb_d   = rx_data;
                state_d = ALU_FUN;
              end
              ALU_FUN: begin
                fun_d   = rx_data[3:0];
                state_d = ISSUE;
              end
              NOOP_FUN: begin
                fun_d   = rx_data[3:0];
                state_d = ISSUE;
              end
              default: begin
                state_d = IDLE;
              end
            endcase
          end
        end
      end
    endcase

`ifdef CMD_TIMEOUT_EN
    // A received byte always beats an expiring counter in the same cycle
    if (inPayload && !rx_valid) begin
      if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
        state_d    = IDLE;
        errPulse_d = 1'b1;
        errCode_d  = ErrTimeout;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  assign cmd_valid = (state_q == ISSUE);
  assign cmd_type  = type_q;
  assign cmd_addr  = addr_q;
  assign cmd_wdata = wdata_q;
  assign cmd_opa   = opa_q;
  assign cmd_opb   = opb_q;
  assign cmd_fun   = fun_q;
  assign err_pulse = errPulse_q;
  assign err_code  = errCode_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Testbench for uart_cmd_decoder: directed byte sequences with hand-computed
// expected command beats and error codes queued into a scoreboard that a
// free-running monitor drains as the decoder produces output.
module tb_uart_cmd_decoder;

  typedef struct {
    logic [1:0] t;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] opa;
    logic [7:0] opb;
    logic [3:0] fun;
  } cmd_t;

  logic       CLK;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_par_err;
  logic       rx_frame_err;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] cmd_opa;
  logic [7:0] cmd_opb;
  logic [3:0] cmd_fun;
  logic       err_pulse;
  logic [2:0] err_code;

  int   vectors;
  int   miscompares;
  cmd_t expCmd[$];
  int   expErr[$];

  uart_cmd_decoder #(
    .DATA_W      (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_par_err   (rx_par_err),
    .rx_frame_err (rx_frame_err),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_type     (cmd_type),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_opa      (cmd_opa),
    .cmd_opb      (cmd_opb),
    .cmd_fun      (cmd_fun),
    .err_pulse    (err_pulse),
    .err_code     (err_code)
  );

  // Free-running clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one byte for exactly one rising edge; called at posedge+1
  task automatic applyStimulus(input logic [7:0] d, input logic par, input logic frm);
    rx_data      = d;
    rx_valid     = 1'b1;
    rx_par_err   = par;
    rx_frame_err = frm;
    @(posedge CLK);
    #1;
    rx_valid     = 1'b0;
    rx_par_err   = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic pushCmd(input logic [1:0] t, input logic [7:0] addr, input logic [7:0] wdata,
                         input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun);
    cmd_t c;
    c.t = t; c.addr = addr; c.wdata = wdata; c.opa = opa; c.opb = opb; c.fun = fun;
    expCmd.push_back(c);
  endtask

  // Monitor: pop and compare on every accepted beat and every error pulse
  always @(negedge CLK) begin
    if (!RST) begin
      if (cmd_valid && cmd_ready) begin
        if (expCmd.size() == 0) begin
          checkOutput("unexpectedCmd", 32'(cmd_type), 32'hFFFF);
        end else begin
          cmd_t c;
          c = expCmd.pop_front();
          checkOutput("cmdType", 32'(cmd_type), 32'(c.t));
          case (c.t)
            2'd0: begin
              checkOutput("cmdAddr", 32'(cmd_addr), 32'(c.addr));
              checkOutput("cmdWdata", 32'(cmd_wdata), 32'(c.wdata));
            end
            2'd1: checkOutput("cmdAddr", 32'(cmd_addr), 32'(c.addr));
            2'd2: begin
              checkOutput("cmdOpa", 32'(cmd_opa), 32'(c.opa));
              checkOutput("cmdOpb", 32'(cmd_opb), 32'(c.opb));
              checkOutput("cmdFun", 32'(cmd_fun), 32'(c.fun));
            end
            default: checkOutput("cmdFun", 32'(cmd_fun), 32'(c.fun));
          endcase
        end
      end
      if (err_pulse) begin
        if (expErr.size() == 0) begin
          checkOutput("unexpectedErr", 32'(err_code), 32'hFFFF);
        end else begin
          checkOutput("errCode", 32'(err_code), 32'(expErr.pop_front()));
        end
      end else if (err_code != 3'd0) begin
        checkOutput("errCodeIdle", 32'(err_code), 32'd0);
      end
    end
  end

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    vectors      = 0;
    miscompares  = 0;
    RST          = 1'b1;
    rx_data      = '0;
    rx_valid     = 1'b0;
    rx_par_err   = 1'b0;
    rx_frame_err = 1'b0;
    cmd_ready    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;

    checkOutput("resetCmdValid", 32'(cmd_valid), 32'd0);
    checkOutput("resetErrPulse", 32'(err_pulse), 32'd0);
    checkOutput("resetErrCode", 32'(err_code), 32'd0);
    checkOutput("resetFields", {cmd_type, cmd_addr, cmd_wdata, cmd_fun},
                32'd0);
    checkOutput("resetOps", {16'd0, cmd_opa, cmd_opb}, 32'd0);
    waitCycles(2);

    // RF write with immediate acceptance: valid one cycle after the last byte, for one cycle
    pushCmd(2'd0, 8'h05, 8'h3C, 8'h00, 8'h00, 4'h0);
    applyStimulus(8'hAA, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b0, 1'b0);
    checkOutput("wrNotEarly", 32'(cmd_valid), 32'd0);
    applyStimulus(8'h3C, 1'b0, 1'b0);
    checkOutput("wrLatency", 32'(cmd_valid), 32'd1);
    waitCycles(1);
    checkOutput("wrOneCycle", 32'(cmd_valid), 32'd0);
    waitCycles(2);

    // ALU ops held under backpressure for 10 cycles
    cmd_ready = 1'b0;
    pushCmd(2'd2, 8'h00, 8'h00, 8'h12, 8'h34, 4'h7);
    applyStimulus(8'hCC, 1'b0, 1'b0);
    applyStimulus(8'h12, 1'b0, 1'b0);
    applyStimulus(8'h34, 1'b0, 1'b0);
    applyStimulus(8'hF7, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("aluHeldValid", 32'(cmd_valid), 32'd1);
      checkOutput("aluHeldFields", {14'd0, cmd_type, cmd_opa, cmd_opb}, {14'd0, 2'd2, 8'h12, 8'h34});
      checkOutput("aluHeldFun", 32'(cmd_fun), 32'h7);
      waitCycles(1);
    end
    cmd_ready = 1'b1;
    waitCycles(1);
    checkOutput("aluReleased", 32'(cmd_valid), 32'd0);
    waitCycles(2);

    // Unknown opcode, then an RF read
    expErr.push_back(2);
    applyStimulus(8'h55, 1'b0, 1'b0);
    waitCycles(1);
    checkOutput("badOpNoCmd", 32'(cmd_valid), 32'd0);
    pushCmd(2'd1, 8'h0A, 8'h00, 8'h00, 8'h00, 4'h0);
    applyStimulus(8'hBB, 1'b0, 1'b0);
    applyStimulus(8'h0A, 1'b0, 1'b0);
    waitCycles(3);

    // Parity error mid-frame, then ALU no-op
    expErr.push_back(1);
    applyStimulus(8'hAA, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b0, 1'b0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    waitCycles(1);
    checkOutput("parErrNoCmd", 32'(cmd_valid), 32'd0);
    pushCmd(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'h2);
    applyStimulus(8'hDD, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    waitCycles(3);

    // Both flags on a payload byte, and a frame error on an opcode byte: code 1 each
    expErr.push_back(1);
    applyStimulus(8'hCC, 1'b0, 1'b0);
    applyStimulus(8'h11, 1'b1, 1'b1);
    expErr.push_back(1);
    applyStimulus(8'hAA, 1'b0, 1'b1);
    waitCycles(2);

    // Overrun while the command is pending, then release
    cmd_ready = 1'b0;
    pushCmd(2'd1, 8'h01, 8'h00, 8'h00, 8'h00, 4'h0);
    expErr.push_back(3);
    applyStimulus(8'hBB, 1'b0, 1'b0);
    applyStimulus(8'h01, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(8'hAA, 1'b0, 1'b0);
    waitCycles(2);
    checkOutput("overrunStillPending", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    waitCycles(1);
    pushCmd(2'd1, 8'h02, 8'h00, 8'h00, 8'h00, 4'h0);
    applyStimulus(8'hBB, 1'b0, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b0);
    waitCycles(3);

    // Overrun byte arriving on the handshake cycle is dropped, not taken as opcode
    cmd_ready = 1'b0;
    pushCmd(2'd3, 8'h00, 8'h00, 8'h00, 8'h00, 4'h5);
    expErr.push_back(3);
    pushCmd(2'd1, 8'h07, 8'h00, 8'h00, 8'h00, 4'h0);
    applyStimulus(8'hDD, 1'b0, 1'b0);
    applyStimulus(8'h05, 1'b0, 1'b0);
    waitCycles(1);
    cmd_ready = 1'b1;
    applyStimulus(8'hAA, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b0, 1'b0);
    waitCycles(3);

    // Silence after an opcode
`ifdef CMD_TIMEOUT_EN
    expErr.push_back(4);
    applyStimulus(8'hAA, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("timeoutErrSeen", 32'(expErr.size()), 32'd0);
    pushCmd(2'd1, 8'h03, 8'h00, 8'h00, 8'h00, 4'h0);
    applyStimulus(8'hBB, 1'b0, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b0);
`else
    applyStimulus(8'hAA, 1'b0, 1'b0);
    waitCycles(40);
    checkOutput("noTimeoutValid", 32'(cmd_valid), 32'd0);
    pushCmd(2'd0, 8'h05, 8'h3C, 8'h00, 8'h00, 4'h0);
    applyStimulus(8'h05, 1'b0, 1'b0);
    applyStimulus(8'h3C, 1'b0, 1'b0);
`endif
    waitCycles(5);

    checkOutput("cmdQueueDrained", 32'(expCmd.size()), 32'd0);
    checkOutput("errQueueDrained", 32'(expErr.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
